// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare direction/target predictor: indexing modes,
// controller states, and metadata layout helpers.
package gshare_predictor_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;
  localparam int unsigned PC_W         = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Weakly-not-taken encoding for a counter of the given width.
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Metadata is {ghr_snapshot, ctr}: the counter occupies the low bits.
  function automatic int unsigned meta_ghr_lsb(input int unsigned ctr_w);
    return ctr_w;
  endfunction

endpackage

// File: rtl/gshare_predictor_bp_table_ram.sv
// Two-port table: combinational read port for prediction, synchronous write
// port for feedback and the init sweep. Reads see pre-write contents.
module gshare_predictor_bp_table_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data_c = mem_q[rd_addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Fetch-stage direction+target predictor: PHT of saturating counters, tagged
// BTB, bimodal/gshare indexing, speculative global history with repair.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned HIST_W = 8,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned MODE   = MODE_GSHARE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bp_oe,
  input  logic [31:0]              bp_pc,
  output logic                     bp_hit,
  output logic                     bp_taken,
  output logic [31:0]              bp_target,
  output logic [HIST_W+CTR_W-1:0]  bp_data,
  input  logic                     fb_we,
  input  logic [31:0]              fb_pc,
  input  logic                     fb_taken,
  input  logic [31:0]              fb_target,
  input  logic                     fb_mispred,
  input  logic [HIST_W+CTR_W-1:0]  fb_data,
  output logic                     busy,
  output logic [31:0]              cnt_hit,
  output logic [31:0]              cnt_pred
);

  localparam int unsigned META_W   = HIST_W + CTR_W;
  localparam int unsigned TGT_W    = PC_W - 1;
  localparam int unsigned BTB_W    = 1 + TAG_W + TGT_W;
  localparam int unsigned TAG_LSB  = 2 + IDX_W;
  localparam int unsigned GHR_LSB  = meta_ghr_lsb(CTR_W);
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctr_init(CTR_W));

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc,
                                               input logic [HIST_W-1:0] hist);
    if (MODE == MODE_GSHARE) begin
      return pc[2 +: IDX_W] ^ IDX_W'(hist);
    end
    return pc[2 +: IDX_W];
  endfunction

  function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] hist,
                                                  input logic bit_in);
    return HIST_W'({hist, bit_in});
  endfunction

  bp_state_e            state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [HIST_W-1:0]    ghr_q, ghr_d;
  logic                 hit_q, hit_d;
  logic                 taken_q, taken_d;
  logic [31:0]          target_q, target_d;
  logic [META_W-1:0]    data_q, data_d;
  logic                 busy_q, busy_d;
  logic [31:0]          cnt_hit_q, cnt_hit_d;
  logic [31:0]          cnt_pred_q, cnt_pred_d;

  logic [IDX_W-1:0]     rd_idx_c, wr_idx_c;
  logic [CTR_W-1:0]     pht_rd_c, pht_wdata_c;
  logic [BTB_W-1:0]     btb_rd_c, btb_wdata_c;
  logic                 pht_we_c, btb_we_c;
  logic                 hit_c, taken_c;
  logic [META_W-1:0]    fb_meta_c;
  logic [HIST_W-1:0]    fb_snap_c;
  logic [CTR_W-1:0]     fb_ctr_c, ctr_upd_c;
  logic                 unused_c;

  assign rd_idx_c = idx_of(bp_pc, ghr_q);

  gshare_predictor_bp_table_ram #(.ADDR_W(IDX_W), .DATA_W(CTR_W)) u_pht (
    .clk       (clk),
    .rd_addr_i (rd_idx_c),
    .rd_data_c (pht_rd_c),
    .we_i      (pht_we_c),
    .wr_addr_i (wr_idx_c),
    .wr_data_i (pht_wdata_c)
  );

  gshare_predictor_bp_table_ram #(.ADDR_W(IDX_W), .DATA_W(BTB_W)) u_btb (
    .clk       (clk),
    .rd_addr_i (rd_idx_c),
    .rd_data_c (btb_rd_c),
    .we_i      (btb_we_c),
    .wr_addr_i (wr_idx_c),
    .wr_data_i (btb_wdata_c)
  );

  // BTB entry layout: {valid, tag, target[31:1]}.
  assign hit_c   = btb_rd_c[BTB_W-1] && (btb_rd_c[TGT_W +: TAG_W] == bp_pc[TAG_LSB +: TAG_W]);
  assign taken_c = hit_c && pht_rd_c[CTR_W-1];

  // Feedback metadata is only looked at while fb_we is high.
  assign fb_meta_c = fb_we ? fb_data : '0;
  assign fb_snap_c = fb_meta_c[GHR_LSB +: HIST_W];
  assign fb_ctr_c  = fb_meta_c[CTR_W-1:0];

  always_comb begin
    ctr_upd_c = fb_ctr_c;
    if (fb_taken) begin
      ctr_upd_c = (fb_ctr_c == CTR_MAX) ? CTR_MAX : fb_ctr_c + CTR_W'(1);
    end else begin
      ctr_upd_c = (fb_ctr_c == '0) ? '0 : fb_ctr_c - CTR_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ghr_d       = ghr_q;
    hit_d       = hit_q;
    taken_d     = taken_q;
    target_d    = target_q;
    data_d      = data_q;
    busy_d      = busy_q;
    cnt_hit_d   = cnt_hit_q;
    cnt_pred_d  = cnt_pred_q;
    pht_we_c    = 1'b0;
    btb_we_c    = 1'b0;
    wr_idx_c    = ptr_q;
    pht_wdata_c = CTR_RESET;
    btb_wdata_c = '0;

    unique case (state_q)
      ST_INIT: begin
        pht_we_c = 1'b1;
        btb_we_c = 1'b1;
        ptr_d    = ptr_q + IDX_W'(1);
        if (&ptr_q) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bp_oe) begin
          hit_d    = hit_c;
          taken_d  = taken_c;
          target_d = hit_c ? {btb_rd_c[TGT_W-1:0], 1'b0} : 32'd0;
          data_d   = {ghr_q, pht_rd_c};
          ghr_d    = hist_push(ghr_q, taken_c);
        end
        if (fb_we) begin
          wr_idx_c    = idx_of(fb_pc, fb_snap_c);
          pht_we_c    = 1'b1;
          pht_wdata_c = ctr_upd_c;
          btb_we_c    = fb_taken;
          btb_wdata_c = {1'b1, fb_pc[TAG_LSB +: TAG_W], fb_target[31:1]};
          cnt_pred_d  = cnt_pred_q + 32'd1;
          cnt_hit_d   = cnt_hit_q + 32'(!fb_mispred);
          // Repair overrides any speculative shift made this cycle.
          if (fb_mispred) begin
            ghr_d = hist_push(fb_snap_c, fb_taken);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      ghr_q      <= '0;
      hit_q      <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      data_q     <= '0;
      busy_q     <= 1'b1;
      cnt_hit_q  <= '0;
      cnt_pred_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ghr_q      <= ghr_d;
      hit_q      <= hit_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      cnt_hit_q  <= cnt_hit_d;
      cnt_pred_q <= cnt_pred_d;
    end
  end

  assign bp_hit    = hit_q;
  assign bp_taken  = taken_q;
  assign bp_target = target_q;
  assign bp_data   = data_q;
  assign busy      = busy_q;
  assign cnt_hit   = cnt_hit_q;
  assign cnt_pred  = cnt_pred_q;

  // PC alignment bits, PC bits above the tag and target bit 0 carry no information.
  assign unused_c = ^{bp_pc[1:0], fb_pc[1:0], fb_target[0],
                      bp_pc >> (TAG_LSB + TAG_W), fb_pc >> (TAG_LSB + TAG_W)};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with an array-level reference model
// checked every cycle, plus hand-computed spot checks.
module tb_gshare_predictor;

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned HIST_W = 8;
  localparam int unsigned CTR_W  = 2;
  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned META_W = HIST_W + CTR_W;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              bp_oe;
  logic [31:0]       bp_pc;
  logic              bp_hit;
  logic              bp_taken;
  logic [31:0]       bp_target;
  logic [META_W-1:0] bp_data;
  logic              fb_we;
  logic [31:0]       fb_pc;
  logic              fb_taken;
  logic [31:0]       fb_target;
  logic              fb_mispred;
  logic [META_W-1:0] fb_data;
  logic              busy;
  logic [31:0]       cnt_hit;
  logic [31:0]       cnt_pred;

  always #5 clk = ~clk;

  gshare_predictor #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .MODE(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bp_oe      (bp_oe),
    .bp_pc      (bp_pc),
    .bp_hit     (bp_hit),
    .bp_taken   (bp_taken),
    .bp_target  (bp_target),
    .bp_data    (bp_data),
    .fb_we      (fb_we),
    .fb_pc      (fb_pc),
    .fb_taken   (fb_taken),
    .fb_target  (fb_target),
    .fb_mispred (fb_mispred),
    .fb_data    (fb_data),
    .busy       (busy),
    .cnt_hit    (cnt_hit),
    .cnt_pred   (cnt_pred)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole tables as arrays, history as a plain integer.
  int          m_pht  [DEPTH];
  bit          m_bv   [DEPTH];
  int          m_btag [DEPTH];
  logic [31:0] m_btgt [DEPTH];
  int          m_ghr;
  int          m_init_left;
  int          m_gnext, m_i, m_c, m_snap;
  bit          e_hit, e_taken, e_busy;
  logic [31:0] e_target, e_cpred, e_chit;
  int          e_data;

  function automatic int idx_of(input logic [31:0] pc, input int g);
    return int'((pc >> 2) & (DEPTH - 1)) ^ g;
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) & ((1 << TAG_W) - 1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ghr = 0; m_init_left = DEPTH;
      e_hit = 0; e_taken = 0; e_target = 0; e_data = 0; e_busy = 1;
      e_cpred = 0; e_chit = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_pht[i] = CTR_HALF - 1;
          m_bv[i]  = 0;
        end
        e_busy = 0;
      end
    end else begin
      m_gnext = m_ghr;
      if (bp_oe) begin
        m_i      = idx_of(bp_pc, m_ghr);
        e_hit    = m_bv[m_i] && (m_btag[m_i] == tag_of(bp_pc));
        e_taken  = e_hit && (m_pht[m_i] >= CTR_HALF);
        e_target = e_hit ? m_btgt[m_i] : 32'd0;
        e_data   = m_ghr * (1 << CTR_W) + m_pht[m_i];
        m_gnext  = (m_ghr * 2 + int'(e_taken)) % (1 << HIST_W);
      end
      if (fb_we) begin
        m_snap = int'(fb_data) >> CTR_W;
        m_c    = int'(fb_data) & CTR_MAX;
        m_i    = idx_of(fb_pc, m_snap);
        m_pht[m_i] = fb_taken ? ((m_c == CTR_MAX) ? CTR_MAX : m_c + 1)
                              : ((m_c == 0) ? 0 : m_c - 1);
        if (fb_taken) begin
          m_bv[m_i]   = 1;
          m_btag[m_i] = tag_of(fb_pc);
          m_btgt[m_i] = fb_target & ~32'h1;
        end
        e_cpred = e_cpred + 1;
        if (!fb_mispred) e_chit = e_chit + 1;
        if (fb_mispred) m_gnext = (m_snap * 2 + int'(fb_taken)) % (1 << HIST_W);
      end
      m_ghr = m_gnext;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",      32'(busy),      32'(e_busy));
      chk("cyc_bp_hit",    32'(bp_hit),    32'(e_hit));
      chk("cyc_bp_taken",  32'(bp_taken),  32'(e_taken));
      chk("cyc_bp_target", bp_target,      e_target);
      chk("cyc_bp_data",   32'(bp_data),   32'(e_data));
      chk("cyc_cnt_pred",  cnt_pred,       e_cpred);
      chk("cyc_cnt_hit",   cnt_hit,        e_chit);
    end
  end

  task automatic step(input bit bo, input logic [31:0] bpc, input bit fw,
                      input logic [31:0] fpc, input bit ft, input logic [31:0] ftgt,
                      input bit fm, input logic [META_W-1:0] fd);
    bp_oe = bo; bp_pc = bpc;
    fb_we = fw; fb_pc = fpc; fb_taken = ft; fb_target = ftgt; fb_mispred = fm; fb_data = fd;
    @(posedge clk); #1;
    bp_oe = 1'b0; fb_we = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic fb(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                    input bit m, input logic [7:0] snap, input logic [1:0] ctr);
    step(1'b0, 32'h0, 1'b1, pc, t, tgt, m, {snap, ctr});
  endtask

  task automatic wait_init(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy === 1'b1 && n < 2000);
    chk(name, 32'(n), 32'd1024);
  endtask

  int n;

  initial begin
    rst = 1'b0; bp_oe = 1'b0; bp_pc = '0; fb_we = 1'b0; fb_pc = '0;
    fb_taken = 1'b0; fb_target = '0; fb_mispred = 1'b0; fb_data = '0;
    #2 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_bp_data", 32'(bp_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Init sweep: requests and feedback during the sweep have no effect.
    bp_oe = 1'b1; bp_pc = 32'h100;
    fb_we = 1'b1; fb_pc = 32'h300; fb_taken = 1'b1; fb_target = 32'h44; fb_data = '0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 8) begin
        chk("init_bp_hit", 32'(bp_hit), 32'd0);
        chk("init_bp_taken", 32'(bp_taken), 32'd0);
        bp_oe = 1'b0; fb_we = 1'b0;
      end
    end while (busy === 1'b1 && n < 2000);
    chk("init_cycles", 32'(n), 32'd1024);
    chk("init_cnt_pred", cnt_pred, 32'd0);

    // Train 0x200 taken three times; counter passes 1->2->3 and saturates.
    fb(32'h200, 1'b1, 32'h80, 1'b0, 8'h00, 2'd1);
    fb(32'h200, 1'b1, 32'h80, 1'b0, 8'h00, 2'd2);
    fb(32'h200, 1'b1, 32'h80, 1'b0, 8'h00, 2'd3);
    query(32'h200);
    chk("train_hit", 32'(bp_hit), 32'd1);
    chk("train_taken", 32'(bp_taken), 32'd1);
    chk("train_target", bp_target, 32'h80);
    chk("train_ctr_sat", 32'(bp_data) & 32'h3, 32'd3);
    chk("train_cnt_pred", cnt_pred, 32'd3);

    // Repair history back to 0, then a same-index different-tag query misses.
    fb(32'h400, 1'b0, 32'h0, 1'b1, 8'h00, 2'd1);
    query(32'h1200);
    chk("alias_ghr", 32'(bp_data) >> 2, 32'h00);
    chk("alias_hit", 32'(bp_hit), 32'd0);
    chk("alias_taken", 32'(bp_taken), 32'd0);

    // Build ghr=0xA5 from speculative shifts: taken hits at history 00,02,14,52.
    fb(32'h3000, 1'b1, 32'h1000, 1'b0, 8'h00, 2'd1);
    fb(32'h3100, 1'b1, 32'h1100, 1'b0, 8'h02, 2'd1);
    fb(32'h3200, 1'b1, 32'h1200, 1'b0, 8'h14, 2'd1);
    fb(32'h3300, 1'b1, 32'h1300, 1'b0, 8'h52, 2'd1);
    query(32'h3000);
    chk("hist_first_taken", 32'(bp_taken), 32'd1);
    query(32'h5000);
    query(32'h3100);
    query(32'h5000);
    query(32'h5000);
    query(32'h3200);
    query(32'h5000);
    query(32'h3300);
    chk("hist_last_target", bp_target, 32'h1300);
    // Mispredict repair with snapshot 0x3C alongside a speculative request.
    step(1'b1, 32'h5000, 1'b1, 32'h6000, 1'b1, 32'h2000, 1'b1, {8'h3C, 2'd1});
    chk("hist_at_req", 32'(bp_data) >> 2, 32'hA5);
    query(32'h5000);
    chk("hist_repaired", 32'(bp_data) >> 2, 32'h79);

    // Same-cycle read and write of index 0x72: old value now, new value next.
    step(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h91, 1'b0, {8'hF2, 2'd1});
    chk("coll_old_hit", 32'(bp_hit), 32'd0);
    chk("coll_old_ctr", 32'(bp_data) & 32'h3, 32'd1);
    query(32'h258);
    chk("coll_new_hit", 32'(bp_hit), 32'd1);
    chk("coll_new_ctr", 32'(bp_data) & 32'h3, 32'd2);
    chk("coll_new_target", bp_target, 32'h90);
    chk("pre_rst_cnt_pred", cnt_pred, 32'd10);
    chk("pre_rst_cnt_hit", cnt_hit, 32'd8);

    // Asynchronous reset mid-cycle clears outputs at once and restarts init.
    #2 rst = 1'b1;
    #1;
    chk("arst_hit", 32'(bp_hit), 32'd0);
    chk("arst_target", bp_target, 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_cnt_pred", cnt_pred, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_init("reinit_cycles", n);
    query(32'h200);
    chk("reinit_hit", 32'(bp_hit), 32'd0);
    chk("reinit_taken", 32'(bp_taken), 32'd0);
    chk("reinit_data", 32'(bp_data), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
